// File: rtl/tile_rom_arb_pkg.sv
// Shared types and constants for the tile ROM arbiter.
// Holds the arbiter state encoding, the fill word returned on a watchdog
// timeout, default widths and a helper that sizes client index fields.
package tile_rom_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    // Data handed back to a cache when the SDRAM never answers.
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADDEAD;

    localparam int DEF_NUM_CLIENTS    = 4;
    localparam int DEF_CLIENT_AW      = 18;
    localparam int DEF_SDRAM_AW       = 22;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Width of a field that holds a client index 0..n-1 (at least 1 bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_rom_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Returns the first set bit of 'eligible' at or after 'rr_ptr', wrapping
// modulo NUM_CLIENTS, plus a flag telling whether any bit was set at all.
module rr_picker
    import tile_rom_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int PTR_W       = ptr_width(DEF_NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] eligible,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [PTR_W-1:0]       grant,
    output logic                   any_valid
);

    int         idx;
    logic [PTR_W-1:0] idx_w;

    // Scan from the farthest offset back to rr_ptr so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default first, otherwise a path that
        // assigns nothing would make synthesis infer a latch.
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
            idx   = (int'(rr_ptr) + off) % NUM_CLIENTS;
            idx_w = PTR_W'(idx);
            if (eligible[idx_w]) begin
                grant     = idx_w;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Tile ROM arbiter: merges the level-held ROM miss requests of the per-layer
// tile caches onto one SDRAM read channel, round-robin, one read in flight.
// A served request stays disarmed until its client drops cli_req, so a cache
// that keeps rom_req high after rom_valid is not served twice.
// Optional watchdog: define TILE_ROM_ARB_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES WAIT cycles, return TIMEOUT_FILL and raise sticky timeout_err.
module tile_rom_arbiter
    import tile_rom_arb_pkg::*;
#(
    parameter int                NUM_CLIENTS    = DEF_NUM_CLIENTS,
    parameter int                CLIENT_AW      = DEF_CLIENT_AW,
    parameter int                SDRAM_AW       = DEF_SDRAM_AW,
    parameter logic [SDRAM_AW-1:0] ROM_BASE     = '0,
    parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CLIENTS-1:0]         cli_req,
    input  logic [NUM_CLIENTS*CLIENT_AW-1:0] cli_addr,
    output logic [NUM_CLIENTS-1:0]         cli_valid,
    output logic [31:0]                    cli_data,
    output logic                           sdram_req,
    output logic [SDRAM_AW-1:0]            sdram_addr,
    input  logic                           sdram_ack,
    input  logic [31:0]                    sdram_data,
    output logic                           busy
`ifdef TILE_ROM_ARB_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int PTR_W = ptr_width(NUM_CLIENTS);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_WAIT = WAIT;

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || CLIENT_AW > SDRAM_AW || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("tile_rom_arbiter: unsupported parameter combination");
    end

    logic [0:0]             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_q;
    logic [PTR_W-1:0]       rr_next;
    logic [NUM_CLIENTS-1:0] armed;
    logic [NUM_CLIENTS-1:0] eligible;
    logic [PTR_W-1:0]       pick;
    logic                   pick_valid;
    logic [CLIENT_AW-1:0]   pick_addr;
    logic                   timed_out;
    logic                   complete;
    logic [31:0]            rsp_data;

    assign eligible  = cli_req & armed;
    assign pick_addr = cli_addr[int'(pick)*CLIENT_AW +: CLIENT_AW];
    assign rr_next   = (grant_q == PTR_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
    assign busy      = (state != ST_IDLE);

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .PTR_W       (PTR_W)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (pick),
        .any_valid (pick_valid)
    );

`ifdef TILE_ROM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // The last permitted WAIT cycle ends without an ack: abort the read.
    assign timed_out = (state == ST_WAIT) && !sdram_ack
                       && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count WAIT cycles of the current read; latch any timeout until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                wait_cnt <= '0;
            end else if (!complete) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // An ack always takes priority over a watchdog abort in the same cycle.
    assign complete = (state == ST_WAIT) && (sdram_ack || timed_out);
    assign rsp_data = sdram_ack ? sdram_data : TIMEOUT_FILL;

    // Grant in IDLE, wait for the read in WAIT, route the answer back.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // sees pre-edge values no matter how the statements are ordered.
        if (!reset_n) begin
            state      <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            cli_valid  <= '0;
            cli_data   <= '0;
            rr_ptr     <= '0;
            grant_q    <= '0;
            armed      <= '1;
        end else begin
            cli_valid <= '0;
            armed     <= armed | ~cli_req;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick;
                        sdram_addr <= ROM_BASE + SDRAM_AW'(pick_addr);
                        sdram_req  <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (complete) begin
                        sdram_req          <= 1'b0;
                        cli_data           <= rsp_data;
                        // A client that already dropped its request is re-armed
                        // at once; a client still holding it stays disarmed.
                        armed[grant_q]     <= ~cli_req[grant_q];
                        // A withdrawn client gets no pulse; the data is dropped.
                        cli_valid[grant_q] <= cli_req[grant_q];
                        rr_ptr             <= rr_next;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Self-checking bench for tile_rom_arbiter: directed scenarios followed by
// randomized client and SDRAM behaviour, checked through a scoreboard fed by
// a transaction-level reference model. Build with TILE_ROM_ARB_TIMEOUT_EN
// defined or undefined; the bench follows the same macro.
module tb_tile_rom_arbiter;

    localparam int          N    = 4;
    localparam int          AW   = 18;
    localparam int          SAW  = 22;
    localparam logic [21:0] BASE = 22'h100000;
    localparam int          TMO  = 8;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     cli_req;
    logic [N*AW-1:0]  cli_addr;
    logic [N-1:0]     cli_valid;
    logic [31:0]      cli_data;
    logic             sdram_req;
    logic [SAW-1:0]   sdram_addr;
    logic             sdram_ack;
    logic [31:0]      sdram_data;
    logic             busy;
`ifdef TILE_ROM_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    tile_rom_arbiter #(
        .NUM_CLIENTS    (N),
        .CLIENT_AW      (AW),
        .SDRAM_AW       (SAW),
        .ROM_BASE       (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cli_req    (cli_req),
        .cli_addr   (cli_addr),
        .cli_valid  (cli_valid),
        .cli_data   (cli_data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_data (sdram_data),
        .busy       (busy)
`ifdef TILE_ROM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur as required", name);
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          client;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t           rsp_q[$];
    logic [SAW-1:0] addr_q[$];

    int          cyc;
    bit          m_busy;
    int          m_grant;
    int          m_rr;
    int          m_cnt;
    bit          m_terr;
    bit          m_armed[N];
    bit          m_done;
    logic [31:0] m_data;

    initial cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_busy = 0;
            m_rr   = 0;
            m_cnt  = 0;
            m_terr = 0;
            m_grant = 0;
            for (int i = 0; i < N; i++) m_armed[i] = 1;
            rsp_q.delete();
            addr_q.delete();
        end else begin
            if (m_busy) begin
                m_done = 0;
                if (sdram_ack) begin
                    m_done = 1;
                    m_data = sdram_data;
                end
`ifdef TILE_ROM_ARB_TIMEOUT_EN
                else if (m_cnt == TMO - 1) begin
                    m_done = 1;
                    m_data = 32'hDEADDEAD;
                    m_terr = 1;
                end else begin
                    m_cnt++;
                end
`endif
                if (m_done) begin
                    if (cli_req[m_grant]) rsp_q.push_back('{m_grant, m_data, cyc});
                    m_armed[m_grant] = 0;
                    m_rr   = (m_grant + 1) % N;
                    m_busy = 0;
                end
            end else begin
                for (int off = 0; off < N; off++) begin
                    int idx;
                    idx = (m_rr + off) % N;
                    if (cli_req[idx] && m_armed[idx]) begin
                        m_grant = idx;
                        m_busy  = 1;
                        m_cnt   = 0;
                        addr_q.push_back(SAW'(BASE + SAW'(cli_addr[idx*AW +: AW])));
                        break;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (!cli_req[i]) m_armed[i] = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit   mon_prev_req = 0;
    rsp_t mon_r;

    always @(negedge clk) begin
        check("sdram_req", sdram_req, m_busy);
        check("busy", busy, m_busy);
`ifdef TILE_ROM_ARB_TIMEOUT_EN
        check("timeout_err", timeout_err, m_terr);
`endif
        if (sdram_req && !mon_prev_req) begin
            if (addr_q.size() == 0) fail("unexpected_sdram_req");
            else check("sdram_addr", sdram_addr, addr_q.pop_front());
        end
        mon_prev_req = sdram_req;
        if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
            fail("missing_cli_valid");
            void'(rsp_q.pop_front());
        end
        if (cli_valid != '0) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_cli_valid", cli_valid, 0);
            end else begin
                mon_r = rsp_q.pop_front();
                check("valid_client", cli_valid, 1 << mon_r.client);
                check("cli_data", cli_data, mon_r.data);
                check("valid_cycle", cyc, mon_r.due);
            end
        end
    end

    // ---------------- SDRAM responder ----------------
    bit          ack_en;
    bit          spurious_en;
    bit          use_fixed;
    logic [31:0] fixed_data;
    int          ack_max;
    int          late_req;
    int          late_done = 0;
    int          dly = -1;

    always @(negedge clk) begin
        sdram_ack = 1'b0;
        if (late_req != late_done) begin
            late_done  = late_req;
            sdram_ack  = 1'b1;
            sdram_data = $urandom;
        end else if (ack_en && sdram_req) begin
            if (dly < 0) dly = $urandom_range(0, ack_max);
            if (dly == 0) begin
                sdram_ack  = 1'b1;
                sdram_data = use_fixed ? fixed_data : $urandom;
                dly = -1;
            end else begin
                dly--;
            end
        end else begin
            dly = -1;
            if (spurious_en && !sdram_req && $urandom_range(0, 7) == 0) begin
                sdram_ack  = 1'b1;
                sdram_data = $urandom;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_valid(output int idx);
        bit seen;
        idx  = -1;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (cli_valid != '0) begin
                seen = 1;
                for (int i = 0; i < N; i++) if (cli_valid[i]) idx = i;
            end
        end
        if (!seen) fail("wait_valid_timeout");
    endtask

    task automatic wait_req();
        bit seen;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (sdram_req) seen = 1;
        end
        if (!seen) fail("wait_req_timeout");
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        cli_addr[i*AW +: AW] = a;
    endtask

    task automatic drop(input int i);
        if (i >= 0 && i < N) cli_req[i] = 1'b0;
    endtask

    int idx;
    int n;
    int hold[N];
    int order[3];

    initial begin
        reset_n     = 1'b0;
        cli_req     = '0;
        cli_addr    = '0;
        ack_en      = 0;
        spurious_en = 0;
        use_fixed   = 0;
        fixed_data  = '0;
        ack_max     = 3;
        late_req    = 0;
        order[0] = 0; order[1] = 2; order[2] = 3;
        for (int i = 0; i < N; i++) hold[i] = 0;

        repeat (3) @(negedge clk);
        check("rst_cli_valid", cli_valid, 0);
        check("rst_cli_data", cli_data, 0);
        check("rst_sdram_addr", sdram_addr, 0);
        check("rst_sdram_req", sdram_req, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        ack_en  = 1;

        // Single request from client 1.
        use_fixed  = 1;
        fixed_data = 32'hCAFEF00D;
        set_addr(1, 18'h00123);
        cli_req[1] = 1'b1;
        @(negedge clk);
        check("t1_req", sdram_req, 1);
        check("t1_addr", sdram_addr, 22'h100123);
        wait_valid(idx);
        check("t1_client", idx, 1);
        check("t1_data", cli_data, 32'hCAFEF00D);
        drop(1);
        use_fixed = 0;
        @(negedge clk);
        check("t1_single_pulse", cli_valid, 0);

        // Simultaneous requests 0, 2, 3 from rr_ptr = 0.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
        cli_req = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            wait_valid(idx);
            check("t2_order", idx, order[k]);
            drop(idx);
        end
        @(negedge clk);
        cli_req = 4'b0011;
        wait_valid(idx);
        check("t2_rr_wrap", idx, 0);
        drop(0);
        wait_valid(idx);
        check("t2_rr_next", idx, 1);
        drop(1);

        // Held request is not served twice; re-arms after a one-cycle drop.
        repeat (2) @(negedge clk);
        cli_req[0] = 1'b1;
        wait_valid(idx);
        check("t3_first", idx, 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (sdram_req) n++;
        end
        check("t3_no_reserve", n, 0);
        cli_req[0] = 1'b0;
        @(negedge clk);
        cli_req[0] = 1'b1;
        wait_valid(idx);
        check("t3_rearmed", idx, 0);
        drop(0);

        // Client 1 withdraws during WAIT; client 2 is next.
        repeat (2) @(negedge clk);
        ack_en  = 0;
        cli_req = 4'b0110;
        wait_req();
        cli_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        ack_en = 1;
        wait_valid(idx);
        check("t4_next_client", idx, 2);
        drop(2);

        // Reset during WAIT, then a late ack.
        repeat (2) @(negedge clk);
        ack_en = 0;
        cli_req[3] = 1'b1;
        wait_req();
        @(negedge clk);
        reset_n = 1'b0;
        cli_req = '0;
        @(negedge clk);
        check("t5_sdram_req", sdram_req, 0);
        check("t5_busy", busy, 0);
        check("t5_cli_valid", cli_valid, 0);
        check("t5_cli_data", cli_data, 0);
        check("t5_sdram_addr", sdram_addr, 0);
        reset_n = 1'b1;
        late_req++;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (cli_valid != '0) n++;
        end
        check("t5_late_ack_ignored", n, 0);
        check("t5_idle_req", sdram_req, 0);

        // No ack at all: timeout build aborts, default build keeps waiting.
        cli_req[2] = 1'b1;
        wait_req();
`ifdef TILE_ROM_ARB_TIMEOUT_EN
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (cli_valid != '0) break;
        end
        check("t6_latency", n, TMO);
        check("t6_valid", cli_valid, 4'b0100);
        check("t6_fill", cli_data, 32'hDEADDEAD);
        check("t6_err", timeout_err, 1);
        drop(2);
        ack_en = 1;
`else
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (cli_valid != '0) n++;
        end
        check("t6_no_valid", n, 0);
        check("t6_still_req", sdram_req, 1);
        check("t6_still_busy", busy, 1);
        ack_en = 1;
        wait_valid(idx);
        check("t6_done", idx, 2);
        drop(2);
`endif

        // Randomized traffic: holds, withdrawals, address churn, stray acks.
        repeat (2) @(negedge clk);
        spurious_en = 1;
        ack_max     = 4;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (cli_req[i]) begin
                    if (cli_valid[i]) hold[i] = $urandom_range(1, 5);
                    if (hold[i] > 0) begin
                        hold[i]--;
                        if (hold[i] == 0) cli_req[i] = 1'b0;
                    end else if ($urandom_range(0, 63) == 0) begin
                        cli_req[i] = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        set_addr(i, AW'($urandom));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_addr(i, AW'($urandom));
                    cli_req[i] = 1'b1;
                end
            end
        end

        // Drain and make sure nothing is left outstanding.
        cli_req     = '0;
        spurious_en = 0;
        n = 0;
        while (n < 50 && busy) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
        repeat (2) @(negedge clk);
        check("rsp_q_empty", rsp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
